// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall/flush control with data-memory wait timeout and halt
module pipeline_ctrl #(
  parameter int WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        branch_taken,
  input  logic        mem_access,
  input  logic        mem_ack,
  output logic        en_if,
  output logic        en_id,
  output logic        en_ex,
  output logic        en_mem,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        mem_req,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} st_t;
  localparam logic [7:0] WLAST = 8'(WAIT_MAX - 1);
  st_t st;
  logic [7:0] wcnt;
  logic lu, mstall, frz, br, lus;
  assign state = st;
  always_comb begin
    lu       = ex_memread && ex_rd != 5'd0 && (ex_rd == id_rs || ex_rd == id_rt);
    mstall   = mem_access && !mem_ack;
    frz      = rst_n && (st == HALT || (st == MEM_WAIT && !mem_ack) || (st == RUN && mstall));
    br       = rst_n && st == RUN && !mstall && branch_taken;
    lus      = rst_n && st == RUN && !mstall && !branch_taken && lu;
    en_if    = !frz && !lus;
    en_id    = !frz && !lus;
    en_ex    = !frz;
    en_mem   = !frz;
    flush_id = br;
    flush_ex = br || lus;
    mem_req  = rst_n && (st == MEM_WAIT || (st == RUN && mem_access));
    halted   = st == HALT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= RUN;
      wcnt      <= 8'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (!en_if && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      case (st)
        RUN: if (mstall) begin
          st   <= MEM_WAIT;
          wcnt <= 8'd1;
        end
        MEM_WAIT: if (mem_ack) begin
          st   <= RUN;
          wcnt <= 8'd0;
        end else if (wcnt == WLAST) st <= HALT;
        else wcnt <= wcnt + 8'd1;
        HALT: st <= HALT;
        default: begin
          st   <= RUN;
          wcnt <= 8'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random checks of pipeline_ctrl against a rule-level model
module tb_pipeline_ctrl;
  localparam int WM = 4;
  logic clk = 0, rst_n = 0;
  logic ex_memread = 0, branch_taken = 0, mem_access = 0, mem_ack = 0;
  logic [4:0] ex_rd = 0, id_rs = 0, id_rt = 0;
  logic en_if, en_id, en_ex, en_mem, flush_id, flush_ex, mem_req, halted;
  logic [15:0] stall_cnt;
  logic [1:0] state;
  int tests = 0, fails = 0;
  int m_st = 0, m_w = 0, m_sc = 0;

  pipeline_ctrl #(.WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rt(id_rt), .branch_taken(branch_taken),
    .mem_access(mem_access), .mem_ack(mem_ack), .en_if(en_if), .en_id(en_id),
    .en_ex(en_ex), .en_mem(en_mem), .flush_id(flush_id), .flush_ex(flush_ex),
    .mem_req(mem_req), .halted(halted), .stall_cnt(stall_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // expected {en_if,en_id,en_ex,en_mem,flush_id,flush_ex,mem_req,halted}
  function automatic logic [7:0] exp_out();
    logic hz;
    hz = ex_memread && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
    if (m_st == 2) return 8'b0000_0001;
    if (m_st == 1) return mem_ack ? 8'b1111_0010 : 8'b0000_0010;
    if (mem_access && !mem_ack) return 8'b0000_0010;
    if (branch_taken) return {6'b111111, mem_access, 1'b0};
    if (hz) return {6'b001101, mem_access, 1'b0};
    return {6'b111100, mem_access, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic ma, input logic ack);
    ex_memread = mr; ex_rd = rd; id_rs = rs; id_rt = rt;
    branch_taken = br; mem_access = ma; mem_ack = ack;
  endtask

  task automatic cycle(input string tag);
    logic [7:0] e;
    int ns, nw, nsc;
    #1;
    e = exp_out();
    chk({tag, "_out"}, 32'({en_if, en_id, en_ex, en_mem, flush_id, flush_ex, mem_req, halted}), 32'(e));
    chk({tag, "_state"}, 32'(state), 32'(m_st));
    chk({tag, "_stall"}, 32'(stall_cnt), 32'(m_sc));
    ns = m_st; nw = m_w;
    nsc = e[7] ? m_sc : (m_sc < 65535 ? m_sc + 1 : 65535);
    if (m_st == 0 && mem_access && !mem_ack) begin ns = 1; nw = 1; end
    else if (m_st == 1) begin
      if (mem_ack) begin ns = 0; nw = 0; end
      else if (m_w == WM - 1) ns = 2;
      else nw = m_w + 1;
    end
    @(posedge clk);
    m_st = ns; m_w = nw; m_sc = nsc;
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0;
    #1;
    m_st = 0; m_w = 0; m_sc = 0;
    chk({tag, "_rst_state"}, 32'(state), 0);
    chk({tag, "_rst_stall"}, 32'(stall_cnt), 0);
    chk({tag, "_rst_memreq"}, 32'(mem_req), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk({tag, "_rst_out"}, 32'({en_if, en_id, en_ex, en_mem, flush_id, flush_ex, mem_req, halted}), 32'h0F0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset("init");
    drive(1, 5, 0, 5, 0, 0, 0); cycle("loaduse");
    chk("loaduse_cnt", 32'(stall_cnt), 1);
    drive(1, 5, 0, 5, 1, 0, 0); cycle("branch_over_lu");
    chk("branch_cnt", 32'(stall_cnt), 1);
    drive(1, 0, 0, 0, 0, 0, 0); cycle("rd_zero");
    drive(0, 0, 0, 0, 0, 1, 1); cycle("zero_wait");
    chk("zero_wait_state", 32'(state), 0);
    drive(0, 0, 0, 0, 0, 1, 0); cycle("mw0");
    drive(1, 7, 7, 0, 1, 1, 0); cycle("mw1_ignore");
    drive(0, 0, 0, 0, 0, 1, 1); cycle("mw_ack");
    chk("mw_cnt", 32'(stall_cnt), 3);
    chk("mw_back_run", 32'(state), 0);
    drive(0, 0, 0, 0, 0, 0, 0); cycle("idle");
    for (int i = 0; i < 400; i++) begin
      if (m_st == 2) do_reset("rnd");
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            1'($urandom_range(0, 1)));
      cycle("rnd");
    end
    do_reset("pre_halt");
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (WM) cycle("frozen");
    cycle("halt");
    chk("halt_flag", 32'(halted), 1);
    drive(0, 0, 0, 0, 1, 1, 1); cycle("halt_ack");
    repeat (2) cycle("halt_hold");
    chk("halt_stay", 32'(state), 2);
    do_reset("post_halt");
    drive(0, 0, 0, 0, 0, 1, 0);
    cycle("mid0");
    cycle("mid1");
    chk("mid_state", 32'(state), 1);
    do_reset("mid_wait");
    drive(0, 0, 0, 0, 0, 0, 0); cycle("after");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
